// File: rtl/kbd_cmd_ctrl.sv
// Key-matrix scanner/debouncer with event FIFO and a small command register map fed by an SPI slave.
// Optional LED registers at addresses 2/3 are built only when KBD_LED_REGS_EN is defined.
//
// state  | meaning
// IDLE   | columns released, waiting for scan enable
// DRIVE  | one column held low for SCAN_DIV clocks, then rows latched
// EVAL   | debounce one key of the latched column per clock
// NEXT   | advance column, continue or park in IDLE
module kbd_cmd_ctrl #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commReady,
    input  logic [2:0]      commAdr,
    input  logic [7:0]      commData,
    input  logic            replyEn,
    output logic [7:0]      replyData,
    input  logic [ROWS-1:0] rowIn,
    output logic [COLS-1:0] colOut,
    output logic [15:0]     led,
    output logic            irq
);
    localparam int NK = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EVAL, S_NEXT} state_t;

    // command synchroniser; address/data are stable long before the strobe
    logic [2:0] rdy_sync;
    logic       cmd_stb, cmd_rd;
    logic [2:0] cmd_adr;
    logic [7:0] cmd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_sync <= 3'b000;
            cmd_stb  <= 1'b0;
            cmd_rd   <= 1'b0;
            cmd_adr  <= 3'd0;
            cmd_data <= 8'h00;
        end else begin
            rdy_sync <= {rdy_sync[1:0], commReady};
            cmd_stb  <= rdy_sync[1] & ~rdy_sync[2];
            if (rdy_sync[1] & ~rdy_sync[2]) begin
                cmd_rd   <= replyEn;
                cmd_adr  <= commAdr;
                cmd_data <= commData;
            end
        end
    end

    logic do_rd, do_wr, flush, ovf_clr, pop;
    logic scan_en, ovf, ne, full, push, do_push, do_pop;
    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    rd_val, push_data;
    logic [15:0]   led_q;

    assign do_rd   = cmd_stb & cmd_rd;
    assign do_wr   = cmd_stb & ~cmd_rd;
    assign flush   = do_wr && (cmd_adr == 3'd4) && cmd_data[1];
    assign ovf_clr = do_wr && (cmd_adr == 3'd0) && cmd_data[0];
    assign ne      = (count != '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = do_rd && (cmd_adr == 3'd1) && ne;

    always_comb begin
        rd_val = 8'h00;
        case (cmd_adr)
            3'd0: rd_val = {4'(count), ovf, 2'b00, ne};
            3'd1: rd_val = ne ? fifo_mem[rd_ptr] : 8'hFF;
`ifdef KBD_LED_REGS_EN
            3'd2: rd_val = led_q[7:0];
            3'd3: rd_val = led_q[15:8];
`endif
            3'd4: rd_val = {7'b0, scan_en};
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            replyData <= 8'h00;
            scan_en   <= 1'b1;
        end else begin
            if (do_rd)
                replyData <= rd_val;
            if (do_wr && (cmd_adr == 3'd4))
                scan_en <= cmd_data[0];
        end
    end

`ifdef KBD_LED_REGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 16'h0000;
        end else if (do_wr) begin
            if (cmd_adr == 3'd2) led_q[7:0]  <= cmd_data;
            if (cmd_adr == 3'd3) led_q[15:8] <= cmd_data;
        end
    end
`else
    assign led_q = 16'h0000;
`endif
    assign led = led_q;

    // scanner
    state_t          state, state_nx;
    logic [DW-1:0]   div_cnt;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row_idx;
    logic [ROWS-1:0] row_s1, row_s2, rows_lat;
    logic [NK-1:0]   key_state;
    logic [2:0]      deb_cnt [NK];
    logic [3:0]      key_idx;
    logic            sample, disagree, cnt_hit;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (scan_en) state_nx = S_DRIVE;
            S_DRIVE: if (div_cnt == '0) state_nx = S_EVAL;
            S_EVAL:  if (row_idx == RW'(ROWS-1)) state_nx = S_NEXT;
            S_NEXT:  state_nx = scan_en ? S_DRIVE : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        colOut = '1;
        if (state == S_DRIVE) colOut[col] = 1'b0;
    end

    assign key_idx   = 4'(col * ROWS) + 4'(row_idx);
    assign sample    = ~rows_lat[row_idx];
    assign disagree  = (sample != key_state[key_idx]);
    assign cnt_hit   = disagree && (deb_cnt[key_idx] == 3'(DEBOUNCE-1));
    assign push      = (state == S_EVAL) && cnt_hit;
    assign push_data = {sample, 3'b000, key_idx};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            col       <= '0;
            row_idx   <= '0;
            row_s1    <= '1;
            row_s2    <= '1;
            rows_lat  <= '1;
            key_state <= '0;
            for (int i = 0; i < NK; i++) deb_cnt[i] <= 3'd0;
        end else begin
            state  <= state_nx;
            row_s1 <= rowIn;
            row_s2 <= row_s1;
            if (state_nx == S_DRIVE && state != S_DRIVE)
                div_cnt <= DW'(SCAN_DIV-1);
            else if (state == S_DRIVE && div_cnt != '0)
                div_cnt <= div_cnt - 1'b1;
            if (state == S_DRIVE && div_cnt == '0) begin
                rows_lat <= row_s2;
                row_idx  <= '0;
            end
            if (state == S_EVAL) begin
                row_idx <= row_idx + 1'b1;
                if (!disagree) begin
                    deb_cnt[key_idx] <= 3'd0;
                end else if (cnt_hit) begin
                    key_state[key_idx] <= sample;
                    deb_cnt[key_idx]   <= 3'd0;
                end else begin
                    deb_cnt[key_idx] <= deb_cnt[key_idx] + 3'd1;
                end
            end
            if (state == S_NEXT)
                col <= (col == CW'(COLS-1)) ? '0 : col + 1'b1;
        end
    end

    // event FIFO; flush beats a same-cycle push, a push into a full FIFO only flags overflow
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (push && full)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= ne | ovf;
    end
endmodule

// File: tb/tb_kbd_cmd_ctrl.sv
// Self-checking bench for kbd_cmd_ctrl: a key-matrix model driven by colOut and a
// frame-level register/FIFO reference model; events are compared as multisets.
module tb_kbd_cmd_ctrl;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEBOUNCE = 3, DEPTH = 8;
    localparam int SCAN_CLKS = COLS * (SCAN_DIV + ROWS + 1);

    logic        clk, rst, commReady, replyEn, irq;
    logic [2:0]  commAdr;
    logic [7:0]  commData, replyData;
    logic [ROWS-1:0] rowIn;
    logic [COLS-1:0] colOut;
    logic [15:0] led;
    logic [15:0] keys;

    kbd_cmd_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                   .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .commReady(commReady), .commAdr(commAdr),
        .commData(commData), .replyEn(replyEn), .replyData(replyData),
        .rowIn(rowIn), .colOut(colOut), .led(led), .irq(irq));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // closed key pulls its row low while its column is driven
    always_comb begin
        rowIn = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (!colOut[c] && keys[c*ROWS + r]) rowIn[r] = 1'b0;
    end

    logic [7:0]  q[$];
    logic        ovf_m, scan_en_m;
    logic [15:0] led_m;
    int total = 0;
    int bad = 0;

    task automatic frame(input logic [2:0] adr, input logic [7:0] data, input logic rd);
        @(negedge clk);
        commAdr = adr; commData = data; replyEn = rd; commReady = 1'b1;
        repeat (5) @(negedge clk);
        commReady = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [7:0] data);
        frame(adr, data, 1'b0);
        case (adr)
            3'd0: if (data[0]) ovf_m = 1'b0;
`ifdef KBD_LED_REGS_EN
            3'd2: led_m[7:0]  = data;
            3'd3: led_m[15:8] = data;
`endif
            3'd4: begin
                scan_en_m = data[0];
                if (data[1]) begin q.delete(); ovf_m = 1'b0; end
            end
            default: ;
        endcase
    endtask

    task automatic rd(input logic [2:0] adr, output logic [7:0] exp);
        exp = 8'h00;
        case (adr)
            3'd0: exp = {4'(q.size()), ovf_m, 2'b00, (q.size() != 0)};
            3'd1: exp = (q.size() != 0) ? q.pop_front() : 8'hFF;
            3'd2: exp = led_m[7:0];
            3'd3: exp = led_m[15:8];
            3'd4: exp = {7'b0, scan_en_m};
            default: exp = 8'h00;
        endcase
        frame(adr, 8'h00, 1'b1);
    endtask

    task automatic settle();
        repeat ((DEBOUNCE + 2) * SCAN_CLKS) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] e;
        int n;
        rst = 1'b1; keys = '0; commReady = 1'b0; commAdr = 3'd0; commData = 8'h00; replyEn = 1'b0;
        q.delete(); ovf_m = 1'b0; scan_en_m = 1'b1; led_m = 16'h0000;
        repeat (3) @(negedge clk);
        total++; if (colOut !== 4'b1111) begin bad++; $display("FAIL reset_col got=%b exp=1111", colOut); end
        total++; if (replyData !== 8'h00) begin bad++; $display("FAIL reset_reply got=%h exp=00", replyData); end
        total++; if (led !== 16'h0000) begin bad++; $display("FAIL reset_led got=%h exp=0000", led); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rst = 1'b0;
        n = 0;
        while (colOut === 4'b1111 && n < 20) begin @(negedge clk); n++; end
        total++; if (colOut !== 4'b1110) begin bad++; $display("FAIL scan_start got=%b exp=1110", colOut); end
        rd(3'd0, e);
        total++; if (replyData !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", replyData); end
        rd(3'd0, e);
        total++; if (replyData !== e) begin bad++; $display("FAIL reset_status2 got=%h exp=%h", replyData, e); end
        rd(3'd4, e);
        total++; if (replyData !== 8'h01) begin bad++; $display("FAIL reset_ctrl got=%h exp=01", replyData); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq2 got=%b exp=0", irq); end
    endtask

    task automatic test_regs();
        logic [7:0] e, d;
        logic [2:0] a;
        wr(3'd2, 8'hA5);
        rd(3'd2, e);
        total++; if (replyData !== e) begin bad++; $display("FAIL led_lo_read got=%h exp=%h", replyData, e); end
        total++; if (led !== led_m) begin bad++; $display("FAIL led_out got=%h exp=%h", led, led_m); end
        rd(3'd6, e);
        total++; if (replyData !== 8'h00) begin bad++; $display("FAIL adr6_read got=%h exp=00", replyData); end
        for (int i = 0; i < 8; i++) begin
            a = 3'($urandom_range(2, 7));
            d = 8'($urandom);
            wr(a, d);
            rd(a, e);
            total++; if (replyData !== e) begin bad++; $display("FAIL reg_rw adr=%0d got=%h exp=%h", a, replyData, e); end
            total++; if (led !== led_m) begin bad++; $display("FAIL reg_led got=%h exp=%h", led, led_m); end
        end
        wr(3'd4, 8'h01);
    endtask

    task automatic test_key_press();
        logic [7:0] e;
        keys[9] = 1'b1;
        settle();
        q.push_back(8'h89);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL press_irq got=%b exp=1", irq); end
        rd(3'd0, e);
        total++; if (replyData !== 8'h11) begin bad++; $display("FAIL press_status got=%h exp=11", replyData); end
        rd(3'd1, e);
        total++; if (replyData !== 8'h89) begin bad++; $display("FAIL press_event got=%h exp=89", replyData); end
        repeat (2) @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL press_irq_clr got=%b exp=0", irq); end
        keys[9] = 1'b0;
        settle();
        q.push_back(8'h09);
        rd(3'd1, e);
        total++; if (replyData !== e) begin bad++; $display("FAIL release_event got=%h exp=%h", replyData, e); end
        keys[9] = 1'b1;
        repeat (SCAN_CLKS - 20) @(negedge clk);
        keys[9] = 1'b0;
        settle();
        rd(3'd0, e);
        total++; if (replyData !== 8'h00) begin bad++; $display("FAIL glitch_status got=%h exp=00", replyData); end
    endtask

    task automatic test_empty_read();
        logic [7:0] e;
        rd(3'd1, e);
        total++; if (replyData !== 8'hFF) begin bad++; $display("FAIL empty_event got=%h exp=FF", replyData); end
        rd(3'd0, e);
        total++; if (replyData !== 8'h00) begin bad++; $display("FAIL empty_status got=%h exp=00", replyData); end
    endtask

    task automatic test_scan_enable();
        logic [7:0] e;
        wr(3'd4, 8'h00);
        repeat (2 * SCAN_CLKS) @(negedge clk);
        total++; if (colOut !== 4'b1111) begin bad++; $display("FAIL scan_off_col got=%b exp=1111", colOut); end
        keys[5] = 1'b1;
        settle();
        rd(3'd0, e);
        total++; if (replyData !== e) begin bad++; $display("FAIL scan_off_status got=%h exp=%h", replyData, e); end
        wr(3'd4, 8'h01);
        settle();
        q.push_back(8'h85);
        rd(3'd1, e);
        total++; if (replyData !== e) begin bad++; $display("FAIL scan_on_event got=%h exp=%h", replyData, e); end
        keys[5] = 1'b0;
        settle();
        q.push_back(8'h05);
        rd(3'd1, e);
        total++; if (replyData !== e) begin bad++; $display("FAIL scan_on_release got=%h exp=%h", replyData, e); end
    endtask

    task automatic test_random();
        logic [7:0] e;
        logic [15:0] mask;
        logic [7:0] got[$], expq[$];
        int k, idx;
        for (int round = 0; round < 5; round++) begin
            k = $urandom_range(1, DEPTH);
            mask = '0;
            for (int i = 0; i < k; i++) begin
                do idx = $urandom_range(0, 15); while (mask[idx]);
                mask[idx] = 1'b1;
            end
            keys = keys ^ mask;
            got.delete(); expq.delete();
            for (int i = 0; i < 16; i++)
                if (mask[i]) begin
                    expq.push_back({keys[i], 3'b000, 4'(i)});
                    q.push_back(8'h00);
                end
            settle();
            rd(3'd0, e);
            total++; if (replyData !== e) begin bad++; $display("FAIL rand_status r=%0d got=%h exp=%h", round, replyData, e); end
            total++; if (irq !== 1'b1) begin bad++; $display("FAIL rand_irq r=%0d got=%b exp=1", round, irq); end
            for (int i = 0; i < k; i++) begin
                rd(3'd1, e);
                got.push_back(replyData);
            end
            got.sort(); expq.sort();
            for (int i = 0; i < k; i++) begin
                total++; if (got[i] !== expq[i]) begin bad++; $display("FAIL rand_event r=%0d i=%0d got=%h exp=%h", round, i, got[i], expq[i]); end
            end
            rd(3'd1, e);
            total++; if (replyData !== 8'hFF) begin bad++; $display("FAIL rand_drained got=%h exp=FF", replyData); end
        end
        keys = '0;
        settle();
        wr(3'd4, 8'h03);
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        logic [15:0] mask;
        int idx;
        mask = '0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            do idx = $urandom_range(0, 15); while (mask[idx]);
            mask[idx] = 1'b1;
        end
        keys = mask;
        settle();
        for (int i = 0; i < DEPTH; i++) q.push_back(8'h00);
        ovf_m = 1'b1;
        rd(3'd0, e);
        total++; if (replyData !== 8'h89) begin bad++; $display("FAIL ovf_status got=%h exp=89", replyData); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL ovf_irq got=%b exp=1", irq); end
        wr(3'd0, 8'h01);
        rd(3'd0, e);
        total++; if (replyData !== 8'h81) begin bad++; $display("FAIL ovf_clear got=%h exp=81", replyData); end
        rd(3'd1, e);
        total++;
        if (replyData[7] !== 1'b1 || replyData[6:4] !== 3'b000 || !mask[replyData[3:0]]) begin
            bad++; $display("FAIL ovf_event got=%h mask=%h", replyData, mask);
        end
        rd(3'd0, e);
        total++; if (replyData !== 8'h71) begin bad++; $display("FAIL ovf_after_pop got=%h exp=71", replyData); end
        wr(3'd4, 8'h03);
        rd(3'd0, e);
        total++; if (replyData !== 8'h00) begin bad++; $display("FAIL flush_status got=%h exp=00", replyData); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL flush_irq got=%b exp=0", irq); end
        rd(3'd4, e);
        total++; if (replyData !== 8'h01) begin bad++; $display("FAIL flush_ctrl got=%h exp=01", replyData); end
        keys = '0;
        settle();
        wr(3'd4, 8'h03);
    endtask

    task automatic test_mid_scan_reset();
        logic [7:0] e;
        int n;
        keys[9] = 1'b1;
        settle();
        q.push_back(8'h89);
        rd(3'd0, e);
        total++; if (replyData !== 8'h11) begin bad++; $display("FAIL pre_rst_status got=%h exp=11", replyData); end
        n = 0;
        while (colOut === 4'b1111 && n < 2 * SCAN_CLKS) begin @(negedge clk); n++; end
        while (colOut !== 4'b1111 && n < 2 * SCAN_CLKS) begin @(negedge clk); n++; end
        total++; if (n >= 2 * SCAN_CLKS) begin bad++; $display("FAIL eval_wait timeout cycles=%0d", n); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete(); ovf_m = 1'b0; scan_en_m = 1'b1; led_m = 16'h0000;
        total++; if (colOut !== 4'b1111) begin bad++; $display("FAIL rst_col got=%b exp=1111", colOut); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
        total++; if (led !== 16'h0000) begin bad++; $display("FAIL rst_led got=%h exp=0000", led); end
        rd(3'd0, e);
        total++; if (replyData !== 8'h00) begin bad++; $display("FAIL rst_status got=%h exp=00", replyData); end
        settle();
        q.push_back(8'h89);
        rd(3'd1, e);
        total++; if (replyData !== e) begin bad++; $display("FAIL rst_key_open got=%h exp=%h", replyData, e); end
        keys[9] = 1'b0;
        settle();
        wr(3'd4, 8'h03);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_key_press();
        test_empty_read();
        test_scan_enable();
        test_random();
        test_overflow();
        test_mid_scan_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
